// File: rtl/imm_extend_stage_pkg.sv
// Shared immediate-format encodings for the immediate extension stage.
package imm_extend_stage_pkg;

    localparam int unsigned IMM_W = 25;
    localparam int unsigned SRC_W = 3;

    typedef enum logic [SRC_W-1:0] {
        IMM_I       = 3'd0,
        IMM_S       = 3'd1,
        IMM_B       = 3'd2,
        IMM_J       = 3'd3,
        IMM_U       = 3'd4,
        IMM_Z       = 3'd5,
        IMM_SH      = 3'd6,
        IMM_ILLEGAL = 3'd7
    } imm_src_e;

endpackage

// File: rtl/imm_extend_stage_decode.sv
// Combinational immediate decoder: selects instruction bits per format and extends to XLEN.
module imm_decode
    import imm_extend_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [IMM_W-1:0] imm,
    input  logic [SRC_W-1:0] imm_src,
    output logic [XLEN-1:0]  value,
    output logic             err
);

    // Format select; signed sources sign-extend through the width cast.
    always_comb begin
        value = '0;
        err   = 1'b0;
        case (imm_src_e'(imm_src))
            IMM_I:  value = XLEN'($signed(imm[24:13]));
            IMM_S:  value = XLEN'($signed({imm[24:18], imm[4:0]}));
            IMM_B:  value = XLEN'($signed({imm[24], imm[0], imm[23:18], imm[4:1], 1'b0}));
            IMM_J:  value = XLEN'($signed({imm[24], imm[12:5], imm[13], imm[23:14], 1'b0}));
            IMM_U:  value = XLEN'($signed({imm[24:5], 12'b0}));
            IMM_Z:  value = XLEN'(imm[12:8]);
            IMM_SH: begin
                if (XLEN == 32) begin
                    value = XLEN'(imm[17:13]);
                end else begin
                    value = XLEN'(imm[18:13]);
                end
            end
            default: begin
                value = '0;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_extend_stage.sv
// Immediate extension stage: decode followed by a 2-entry skid buffer.
module imm_extend_stage
    import imm_extend_stage_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMM_W-1:0] imm,
    input  logic [SRC_W-1:0] imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [XLEN-1:0]   dec_imm;
    logic              dec_err;
    logic [XLEN-1:0]   skid_imm;
    logic [TAG_W-1:0]  skid_tag;
    logic              skid_err;
    logic              in_xfer;
    logic              out_xfer;
    logic              load_out_in;
    logic              load_out_skid;
    logic              load_skid;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .imm     (imm),
        .imm_src (imm_src),
        .value   (dec_imm),
        .err     (dec_err)
    );

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Next state and register load enables; flush overrides any transfer.
    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d     = ST_ONE;
                    load_out_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_out_in = 1'b1;
                end else if (in_xfer) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    state_d       = ST_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d       = ST_EMPTY;
            load_out_in   = 1'b0;
            load_out_skid = 1'b0;
            load_skid     = 1'b0;
        end
    end

    // State register with handshake flags derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d != ST_FULL);
            out_valid <= (state_d != ST_EMPTY);
        end
    end

    // Output and skid payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_imm  <= '0;
            out_tag  <= '0;
            out_err  <= 1'b0;
            skid_imm <= '0;
            skid_tag <= '0;
            skid_err <= 1'b0;
        end else begin
            if (load_out_in) begin
                out_imm <= dec_imm;
                out_tag <= in_tag;
                out_err <= dec_err;
            end else if (load_out_skid) begin
                out_imm <= skid_imm;
                out_tag <= skid_tag;
                out_err <= skid_err;
            end
            if (load_skid) begin
                skid_imm <= dec_imm;
                skid_tag <= in_tag;
                skid_err <= dec_err;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage at XLEN=32 and XLEN=64.
module tb_imm_extend_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [24:0] imm;
    logic [2:0]  imm_src;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready32,  out_valid32,  out_err32;
    logic [31:0] out_imm32;
    logic [4:0]  out_tag32;
    logic        in_ready64,  out_valid64,  out_err64;
    logic [63:0] out_imm64;
    logic [4:0]  out_tag64;

    int n_checks = 0;
    int n_fail   = 0;

    imm_extend_stage #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .imm(imm), .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32)
    );

    imm_extend_stage #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .imm(imm), .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid32); end
        n_checks++; if (in_ready32 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready32); end
        n_checks++; if (out_imm32 !== 32'h0) begin n_fail++; $display("FAIL reset_out_imm: got %h expected 0", out_imm32); end
        n_checks++; if (out_tag32 !== 5'd0) begin n_fail++; $display("FAIL reset_out_tag: got %h expected 0", out_tag32); end
        n_checks++; if (out_err32 !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b expected 0", out_err32); end
        n_checks++; if (out_imm64 !== 64'h0) begin n_fail++; $display("FAIL reset_out_imm64: got %h expected 0", out_imm64); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_formats();
        logic [2:0]  srcs [9];
        logic [24:0] imms [9];
        logic [31:0] e32  [9];
        logic [63:0] e64  [9];
        logic        eerr [9];
        srcs[0] = 3'd0; imms[0] = 25'h1FFE001; e32[0] = 32'hFFFFFFFF; e64[0] = 64'hFFFFFFFFFFFFFFFF; eerr[0] = 1'b0;
        srcs[1] = 3'd1; imms[1] = 25'h0040004; e32[1] = 32'h00000024; e64[1] = 64'h24;               eerr[1] = 1'b0;
        srcs[2] = 3'd2; imms[2] = 25'h1FC001D; e32[2] = 32'hFFFFFFFC; e64[2] = 64'hFFFFFFFFFFFFFFFC; eerr[2] = 1'b0;
        srcs[3] = 3'd3; imms[3] = 25'h0006020; e32[3] = 32'h00001802; e64[3] = 64'h1802;             eerr[3] = 1'b0;
        srcs[4] = 3'd4; imms[4] = 25'h02468A1; e32[4] = 32'h12345000; e64[4] = 64'h12345000;         eerr[4] = 1'b0;
        srcs[5] = 3'd4; imms[5] = 25'h1000000; e32[5] = 32'h80000000; e64[5] = 64'hFFFFFFFF80000000; eerr[5] = 1'b0;
        srcs[6] = 3'd5; imms[6] = 25'h1FFFFFF; e32[6] = 32'h0000001F; e64[6] = 64'h1F;               eerr[6] = 1'b0;
        srcs[7] = 3'd6; imms[7] = 25'h007E000; e32[7] = 32'h0000001F; e64[7] = 64'h3F;               eerr[7] = 1'b0;
        srcs[8] = 3'd7; imms[8] = 25'h1FFFFFF; e32[8] = 32'h00000000; e64[8] = 64'h0;                eerr[8] = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            imm_src  = srcs[i];
            imm      = imms[i];
            in_tag   = 5'(i + 1);
            tick();
            n_checks++; if (out_valid32 !== 1'b1) begin n_fail++; $display("FAIL fmt_valid[%0d]: got %b expected 1", i, out_valid32); end
            n_checks++; if (out_imm32 !== e32[i]) begin n_fail++; $display("FAIL fmt_imm32[%0d]: got %h expected %h", i, out_imm32, e32[i]); end
            n_checks++; if (out_imm64 !== e64[i]) begin n_fail++; $display("FAIL fmt_imm64[%0d]: got %h expected %h", i, out_imm64, e64[i]); end
            n_checks++; if (out_err32 !== eerr[i] || out_err64 !== eerr[i]) begin n_fail++; $display("FAIL fmt_err[%0d]: got %b/%b expected %b", i, out_err32, out_err64, eerr[i]); end
            n_checks++; if (out_tag32 !== 5'(i + 1)) begin n_fail++; $display("FAIL fmt_tag[%0d]: got %0d expected %0d", i, out_tag32, i + 1); end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL fmt_drain: got %b expected 0", out_valid32); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm_src   = 3'd0;
        imm = 25'h0002000; in_tag = 5'd1;
        tick();
        n_checks++; if (out_valid32 !== 1'b1 || out_tag32 !== 5'd1) begin n_fail++; $display("FAIL b2b_first: got v=%b tag=%0d expected v=1 tag=1", out_valid32, out_tag32); end
        n_checks++; if (in_ready32 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_one: got %b expected 1", in_ready32); end
        imm = 25'h0004000; in_tag = 5'd2;
        tick();
        n_checks++; if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %b/%b expected 0", in_ready32, in_ready64); end
        n_checks++; if (out_tag32 !== 5'd1 || out_imm32 !== 32'd1) begin n_fail++; $display("FAIL b2b_stall1: got tag=%0d imm=%h expected tag=1 imm=1", out_tag32, out_imm32); end
        imm = 25'h0006000; in_tag = 5'd3;
        tick();
        n_checks++; if (in_ready32 !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_hold: got %b expected 0", in_ready32); end
        n_checks++; if (out_tag32 !== 5'd1 || out_imm32 !== 32'd1 || out_valid32 !== 1'b1) begin n_fail++; $display("FAIL b2b_stall2: got v=%b tag=%0d imm=%h expected v=1 tag=1 imm=1", out_valid32, out_tag32, out_imm32); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_tag32 !== 5'd2 || out_imm32 !== 32'd2) begin n_fail++; $display("FAIL b2b_second: got tag=%0d imm=%h expected tag=2 imm=2", out_tag32, out_imm32); end
        n_checks++; if (in_ready32 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_back: got %b expected 1", in_ready32); end
        tick();
        n_checks++; if (out_tag32 !== 5'd3 || out_imm32 !== 32'd3 || out_valid32 !== 1'b1) begin n_fail++; $display("FAIL b2b_third: got v=%b tag=%0d imm=%h expected v=1 tag=3 imm=3", out_valid32, out_tag32, out_imm32); end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got v=%b r=%b expected v=0 r=1", out_valid32, in_ready32); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm_src   = 3'd0;
        imm = 25'h0008000; in_tag = 5'd4;
        tick();
        in_tag = 5'd5;
        tick();
        n_checks++; if (in_ready32 !== 1'b0) begin n_fail++; $display("FAIL flush_full: got %b expected 0", in_ready32); end
        flush = 1'b1; in_tag = 5'd9;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got v=%b r=%b expected v=0 r=1", out_valid32, in_ready32); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin n_fail++; $display("FAIL flush_nothing[%0d]: got %b/%b expected 0", i, out_valid32, out_valid64); end
        end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm_src   = 3'd0;
        imm = 25'h000A000; in_tag = 5'd6;
        tick();
        in_tag = 5'd7;
        tick();
        in_valid = 1'b0;
        n_checks++; if (in_ready32 !== 1'b0) begin n_fail++; $display("FAIL rstfull_full: got %b expected 0", in_ready32); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin n_fail++; $display("FAIL rstfull_valid: got %b/%b expected 0", out_valid32, out_valid64); end
        n_checks++; if (in_ready32 !== 1'b1 || out_tag32 !== 5'd0) begin n_fail++; $display("FAIL rstfull_ready: got r=%b tag=%0d expected r=1 tag=0", in_ready32, out_tag32); end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        imm = 25'h0002000; in_tag = 5'd8;
        tick();
        n_checks++; if (out_valid32 !== 1'b1 || out_tag32 !== 5'd8 || out_imm32 !== 32'd1) begin n_fail++; $display("FAIL rstfull_after: got v=%b tag=%0d imm=%h expected v=1 tag=8 imm=1", out_valid32, out_tag32, out_imm32); end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL rstfull_drain: got %b expected 0", out_valid32); end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        imm       = '0;
        imm_src   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        test_reset();
        test_formats();
        test_back_to_back();
        test_flush();
        test_reset_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
